// File: rtl/tiles_pkg.sv
// rtl/tiles_pkg.sv - shared playfield geometry, colours and sequencer enums
package tiles_pkg;

    localparam int LANE_NONE   = 0;
    localparam int DEF_LANE_X0 = 120;
    localparam int DEF_LANE_W  = 20;
    localparam int DEF_ROW_H   = 40;
    localparam int SCREEN_W    = 320;
    localparam int SCREEN_H    = 240;

    localparam logic [2:0] COLOR_WHITE = 3'b111;
    localparam logic [2:0] COLOR_BLACK = 3'b000;

    typedef enum logic {ERASE, DRAW} phase_t;

    typedef enum logic [1:0] {S_IDLE, S_SPAN, S_DONE} state_t;

endpackage

// File: rtl/row_render_seq_if.sv
// rtl/row_render_seq_if.sv - pixel stream toward the VGA plot port
interface row_render_seq_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;

    modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/span_walker.sv
// rtl/span_walker.sv - emits one horizontal span of pixels, holding under back-pressure
module span_walker #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               load,
    input  logic [X_W-1:0]     x_start,
    input  logic [X_W-1:0]     length,
    input  logic [Y_W-1:0]     y,
    input  logic [COLOR_W-1:0] color,
    row_render_seq_if.master   pix,
    output logic               last
);

    logic [X_W-1:0] x_end;

    assign last = pix.pix_valid && pix.pix_ready && (pix.pix_x == x_end);

    // A zero length loads an empty span: nothing is presented for it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_color <= '0;
            x_end         <= '0;
        end else if (load) begin
            pix.pix_valid <= (length != '0);
            pix.pix_x     <= x_start;
            pix.pix_y     <= y;
            pix.pix_color <= color;
            x_end         <= x_start + length - 1'b1;
        end else if (pix.pix_valid && pix.pix_ready) begin
            if (pix.pix_x == x_end)
                pix.pix_valid <= 1'b0;
            else
                pix.pix_x <= pix.pix_x + 1'b1;
        end
    end

endmodule

// File: rtl/row_render_seq.sv
// rtl/row_render_seq.sv - per-frame erase/draw tile sequencer feeding the pixel stream
module row_render_seq
    import tiles_pkg::*;
#(
    parameter int NUM_ROWS  = 6,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int LANE_X0   = DEF_LANE_X0,
    parameter int ROW_H     = DEF_ROW_H,
    parameter int COLOR_W   = 3,
    parameter int X_W       = $clog2(SCREEN_W),
    parameter int Y_W       = $clog2(SCREEN_H),
    localparam int LC_W     = $clog2(NUM_LANES + 1),
    localparam int OFF_W    = $clog2(ROW_H)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [NUM_ROWS*LC_W-1:0] old_lane,
    input  logic [NUM_ROWS*LC_W-1:0] new_lane,
    input  logic [OFF_W-1:0]         erase_offset,
    input  logic [OFF_W-1:0]         draw_offset,
    input  logic [COLOR_W-1:0]       erase_color,
    input  logic [COLOR_W-1:0]       draw_color,
    row_render_seq_if.master         pix,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    function automatic logic [OFF_W-1:0] sat(input logic [OFF_W-1:0] off);
        return (int'(off) >= ROW_H) ? OFF_W'(ROW_H - 1) : off;
    endfunction

    state_t                   state;
    phase_t                   phase;
    logic [ROW_W-1:0]         row;
    logic [NUM_ROWS*LC_W-1:0] sh_old, sh_new;
    logic [OFF_W-1:0]         sh_eoff, sh_doff;
    logic [COLOR_W-1:0]       sh_ecol, sh_dcol;

    logic               last_span, advance, load, last_acc, span_ok;
    logic [ROW_W-1:0]   nrow;
    phase_t             nphase;
    logic [LC_W-1:0]    code;
    logic [OFF_W-1:0]   off;
    logic [COLOR_W-1:0] col;
    logic [X_W-1:0]     x_start, length;
    logic [Y_W-1:0]     y_start;

    // Next span is selected and loaded in the same cycle the current one
    // finishes, so consecutive spans stream without a bubble.
    always_comb begin
        last_span = (phase == DRAW) && (int'(row) == NUM_ROWS - 1);
        advance   = (state == S_SPAN) && (!pix.pix_valid || last_acc);
        nrow      = row;
        nphase    = DRAW;
        if (phase == DRAW) begin
            nrow   = row + 1'b1;
            nphase = ERASE;
        end
        if (state == S_IDLE) begin
            nrow   = '0;
            nphase = ERASE;
            code   = old_lane[LC_W-1:0];
            off    = sat(erase_offset);
            col    = erase_color;
        end else if (nphase == ERASE) begin
            code   = sh_old[nrow*LC_W +: LC_W];
            off    = sh_eoff;
            col    = sh_ecol;
        end else begin
            code   = sh_new[nrow*LC_W +: LC_W];
            off    = sh_doff;
            col    = sh_dcol;
        end
        span_ok = (code != LC_W'(LANE_NONE)) && (int'(code) <= NUM_LANES);
        x_start = X_W'(LANE_X0 + (int'(code) - 1) * LANE_W);
        length  = span_ok ? X_W'(LANE_W) : '0;
        y_start = Y_W'(int'(nrow) * ROW_H + int'(off));
        load    = (state == S_IDLE && start) || (advance && !last_span);
    end

    span_walker #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W)
    ) u_walker (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .x_start (x_start),
        .length  (length),
        .y       (y_start),
        .color   (col),
        .pix     (pix),
        .last    (last_acc)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= S_IDLE;
            phase   <= ERASE;
            row     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sh_old  <= '0;
            sh_new  <= '0;
            sh_eoff <= '0;
            sh_doff <= '0;
            sh_ecol <= '0;
            sh_dcol <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_old  <= old_lane;
                        sh_new  <= new_lane;
                        sh_eoff <= sat(erase_offset);
                        sh_doff <= sat(draw_offset);
                        sh_ecol <= erase_color;
                        sh_dcol <= draw_color;
                        row     <= '0;
                        phase   <= ERASE;
                        busy    <= 1'b1;
                        state   <= S_SPAN;
                    end
                end
                S_SPAN: begin
                    if (advance) begin
                        if (last_span) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            row   <= nrow;
                            phase <= nphase;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
